magnetron_power_ctrl: RTL and testbench

Clocked, parametrised successor to the combinational set/reset magnetron control. Adds a run/pause/idle state machine, start-edge detection, and duty-cycled power levels. A slotted on/off pattern inside a fixed power period replaces plain on/off. Sits between the keypad/timer logic and the magnetron driver; mag_on drives the HV relay.

---
 rtl/magnetron_power_ctrl.sv | 134 +++++++++++++
 tb/tb_magnetron_power_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_power_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | magnetron_power_ctrl                                                     |
// | Cook/pause/idle control with start-edge detect and a slotted duty cycle. |
// | Optional MAG_MIN_OFF_EN macro adds a minimum magnetron off-time guard.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module magnetron_power_ctrl #(
    parameter int PERIOD_SLOTS  = 10,
    parameter int LVL_W         = 4,
    parameter int MIN_OFF_TICKS = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic             tick,
    input  logic [LVL_W-1:0] power_level,
    output logic             mag_on,
    output logic             cooking,
    output logic             paused
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [LVL_W-1:0] SLOTS = LVL_W'(PERIOD_SLOTS);
    localparam logic [LVL_W-1:0] LAST  = LVL_W'(PERIOD_SLOTS - 1);

    if (PERIOD_SLOTS < 2 || PERIOD_SLOTS > 255 || (1 << LVL_W) <= PERIOD_SLOTS ||
        MIN_OFF_TICKS < 0) begin : g_bad_params
        $error("magnetron_power_ctrl: illegal parameter combination");
    end

    state_t           state, state_n;
    logic [LVL_W-1:0] phase, phase_n;
    logic [LVL_W-1:0] lvl_q, lvl_n;
    logic [LVL_W-1:0] lvl_clamped;
    logic             start_prev;
    logic             start_ev;
    logic             duty_on;
    logic             mag_on_n;

`ifdef MAG_MIN_OFF_EN
    localparam int GW = $clog2(MIN_OFF_TICKS + 1) + 1;
    logic [GW-1:0] guard, guard_dec, guard_n;
`endif

    always_comb begin
        start_ev    = start_prev & ~startn;
        lvl_clamped = (power_level >= SLOTS) ? SLOTS : power_level;

        // Priority: clear > door open > stop > timer_done > start.
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (clearn && door_closed && stopn && !timer_done && start_ev)
                    state_n = ST_COOK;
            end
            ST_COOK: begin
                if (!clearn)                     state_n = ST_IDLE;
                else if (!door_closed || !stopn) state_n = ST_PAUSE;
                else if (timer_done)             state_n = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!clearn) begin
                    state_n = ST_IDLE;
                end else if (door_closed && stopn) begin
                    if (timer_done)    state_n = ST_IDLE;
                    else if (start_ev) state_n = ST_COOK;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        phase_n = '0;
        lvl_n   = lvl_q;
        if (state_n == ST_COOK) begin
            if (state != ST_COOK) begin
                lvl_n = lvl_clamped;
            end else if (tick) begin
                if (phase == LAST) lvl_n   = lvl_clamped;
                else               phase_n = phase + LVL_W'(1);
            end else begin
                phase_n = phase;
            end
        end

        duty_on = (state_n == ST_COOK) && (phase_n < lvl_n) && door_closed;

`ifdef MAG_MIN_OFF_EN
        // Guard never runs while mag_on is high, so the reload cannot loop back.
        guard_dec = (guard != '0 && tick) ? guard - GW'(1) : guard;
        mag_on_n  = duty_on && (guard_dec == '0);
        guard_n   = (mag_on && !mag_on_n) ? GW'(MIN_OFF_TICKS) : guard_dec;
`else
        mag_on_n  = duty_on;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            phase      <= '0;
            lvl_q      <= '0;
            start_prev <= 1'b1;
            mag_on     <= 1'b0;
            cooking    <= 1'b0;
            paused     <= 1'b0;
`ifdef MAG_MIN_OFF_EN
            guard      <= '0;
`endif
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            lvl_q      <= lvl_n;
            start_prev <= startn;
            mag_on     <= mag_on_n;
            cooking    <= (state_n != ST_IDLE);
            paused     <= (state_n == ST_PAUSE);
`ifdef MAG_MIN_OFF_EN
            guard      <= guard_n;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_magnetron_power_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_magnetron_power_ctrl                                                  |
// | Scoreboard bench: stimulus pushes predicted outputs, monitor compares.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_magnetron_power_ctrl;

    localparam int P       = 10;
    localparam int LW      = 4;
    localparam int MIN_OFF = 3;

    logic clk = 1'b0;
    logic resetn, startn, stopn, clearn, door_closed, timer_done, tick;
    logic [LW-1:0] power_level;
    logic mag_on, cooking, paused;

    // Values applied at the next negedge by step()
    logic s_resetn = 1'b0, s_startn = 1'b1, s_stopn = 1'b1, s_clearn = 1'b1;
    logic s_door = 1'b1, s_timer = 1'b0, s_tick = 1'b0;
    logic [LW-1:0] s_pl = '0;

    typedef struct { bit mag; bit cook; bit pause; } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0=idle 1=cook 2=pause
    int m_mode = 0, m_slot = 0, m_lvl = 0, m_guard = 0;
    bit m_prev = 1'b1, m_mag = 1'b0;

    magnetron_power_ctrl #(
        .PERIOD_SLOTS (P),
        .LVL_W        (LW),
        .MIN_OFF_TICKS(MIN_OFF)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .startn     (startn),
        .stopn      (stopn),
        .clearn     (clearn),
        .door_closed(door_closed),
        .timer_done (timer_done),
        .tick       (tick),
        .power_level(power_level),
        .mag_on     (mag_on),
        .cooking    (cooking),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int nm;
        int clamp;
        bit ev;
        bit want;
        clamp = (int'(power_level) > P) ? P : int'(power_level);
        if (!resetn) begin
            m_mode = 0; m_slot = 0; m_lvl = 0; m_prev = 1'b1; m_mag = 1'b0; m_guard = 0;
        end else begin
            ev     = m_prev && !startn;
            m_prev = startn;
            nm     = m_mode;
            if (!clearn)                     nm = 0;
            else if (!door_closed || !stopn) nm = (m_mode == 0) ? 0 : 2;
            else if (timer_done)             nm = 0;
            else if (ev && m_mode != 1)      nm = 1;
            if (nm == 1) begin
                if (m_mode != 1) begin
                    m_slot = 0;
                    m_lvl  = clamp;
                end else if (tick) begin
                    m_slot++;
                    if (m_slot == P) begin
                        m_slot = 0;
                        m_lvl  = clamp;
                    end
                end
            end else begin
                m_slot = 0;
            end
            m_mode = nm;
            want = (m_mode == 1) && (m_slot < m_lvl) && door_closed;
`ifdef MAG_MIN_OFF_EN
            if (m_guard > 0 && tick) m_guard--;
            if (m_guard > 0) want = 1'b0;
            if (m_mag && !want) m_guard = MIN_OFF;
`endif
            m_mag = want;
        end
        sb.push_back('{m_mag, m_mode != 0, m_mode == 2});
    endtask

    task automatic step();
        @(negedge clk);
        resetn      = s_resetn;
        startn      = s_startn;
        stopn       = s_stopn;
        clearn      = s_clearn;
        door_closed = s_door;
        timer_done  = s_timer;
        tick        = s_tick;
        power_level = s_pl;
        model_step();
    endtask

    task automatic steps(input int n, input bit alt_tick);
        for (int i = 0; i < n; i++) begin
            s_tick = alt_tick ? bit'(i % 2) : 1'b1;
            step();
        end
        s_tick = 1'b0;
    endtask

    task automatic press_start();
        s_startn = 1'b0; step();
        s_startn = 1'b1; step();
    endtask

    // Monitor: one output word per clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if ({mag_on, cooking, paused} !== {e.mag, e.cook, e.pause}) begin
                fails++;
                $display("FAIL outputs t=%0t got mag_on=%b cooking=%b paused=%b expected %b %b %b",
                         $time, mag_on, cooking, paused, e.mag, e.cook, e.pause);
            end
        end
    end

    initial begin
        resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; timer_done = 1'b0; tick = 1'b0; power_level = '0;
        #2;
        tests++;
        if ({mag_on, cooking, paused} !== 3'b000) begin
            fails++;
            $display("FAIL reset_state got %b expected 000", {mag_on, cooking, paused});
        end
        steps(3, 1'b0);
        s_resetn = 1'b1;
        steps(2, 1'b0);

        // Full power for 30 ticks, then timer_done
        s_pl = 4'd10; press_start();
        steps(60, 1'b1);
        s_timer = 1'b1; step(); s_timer = 1'b0; steps(2, 1'b0);

        // Half power, level change mid-period
        s_pl = 4'd5; press_start();
        steps(20, 1'b0);
        steps(3, 1'b0);
        s_pl = 4'd2; steps(25, 1'b0);
        s_clearn = 1'b0; step(); s_clearn = 1'b1; step();

        // Door open mid-cook, close, restart from pause
        s_pl = 4'd10; press_start(); steps(2, 1'b0);
        s_door = 1'b0; steps(2, 1'b0);
        s_door = 1'b1; steps(5, 1'b0);
        press_start(); steps(6, 1'b0);
        s_clearn = 1'b0; step(); s_clearn = 1'b1; step();

        // Start with stop held, held start key, then clear from pause
        s_stopn = 1'b0; s_startn = 1'b0; step();
        s_stopn = 1'b1; steps(50, 1'b0);
        s_startn = 1'b1; step();
        press_start(); steps(3, 1'b0);
        s_stopn = 1'b0; step(); s_stopn = 1'b1; steps(2, 1'b0);
        s_clearn = 1'b0; step(); s_clearn = 1'b1; step();

        // Zero power, then asynchronous reset mid-cook
        s_pl = 4'd0; press_start(); steps(20, 1'b0);
        s_pl = 4'd15; press_start(); steps(4, 1'b0);
        s_resetn = 1'b0; step();
        #1;
        tests++;
        if ({mag_on, cooking, paused} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset got %b expected 000", {mag_on, cooking, paused});
        end
        step(); s_resetn = 1'b1; steps(2, 1'b0);

        // Power 8: off-guard interaction across the period wrap
        s_pl = 4'd8; press_start(); steps(25, 1'b0);
        s_clearn = 1'b0; step(); s_clearn = 1'b1; step();

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)   s_startn = ~s_startn;
            s_stopn  = ($urandom_range(0, 24) != 0);
            s_clearn = ($urandom_range(0, 59) != 0);
            s_door   = ($urandom_range(0, 29) != 0);
            s_timer  = ($urandom_range(0, 49) == 0);
            s_tick   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0) s_pl = LW'($urandom_range(0, 15));
            s_resetn = ($urandom_range(0, 499) != 0);
            step();
        end
        s_resetn = 1'b1;
        steps(3, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
